// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MULT/DIV sequencer owning the HI/LO registers.
// An accepted MD op is computed into shadow registers at the accepting edge,
// busy is held for a fixed per-class latency, then the shadow commits to HI/LO.
// Optional build macro: MD_FLUSH_EN adds a flush input that aborts an op in flight.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
`ifdef MD_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        md_stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_s_q, hi_s_d, lo_s_q, lo_s_d;

  logic               flush_w;
  logic               is_mult, is_div, is_md;
  logic               accept, commit;

`ifdef MD_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Command decode; reserved op 7 and NONE fall through as no-ops
  assign is_mult = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign is_md   = is_mult || is_div;
  assign accept  = (state_q == S_IDLE) && start && !flush_w && is_md;
  assign commit  = (state_q == S_BUSY) && !flush_w && (cnt_q == CNT_W'(1));

  // Multiplier: both flavours computed at full 64-bit width
  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});

  // Divider: signed done on magnitudes so the -2^31 / -1 case needs no special path
  logic        div_zero;
  logic [31:0] abs_a, abs_b, divisor_s, divisor_u;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;
  assign div_zero  = (rt == 32'd0);
  assign abs_a     = rs[31] ? (32'd0 - rs) : rs;
  assign abs_b     = rt[31] ? (32'd0 - rt) : rt;
  assign divisor_s = div_zero ? 32'd1 : abs_b;
  assign divisor_u = div_zero ? 32'd1 : rt;
  assign sq_mag    = abs_a / divisor_s;
  assign sr_mag    = abs_a % divisor_s;
  assign sq        = (rs[31] ^ rt[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr        = rs[31] ? (32'd0 - sr_mag) : sr_mag;
  assign uq        = rs / divisor_u;
  assign ur        = rs % divisor_u;

  // Result select for the op being accepted this cycle
  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = div_zero ? {rs, 32'hFFFF_FFFF} : {sr, sq};
      OP_DIVU:  {res_hi, res_lo} = div_zero ? {rs, 32'hFFFF_FFFF} : {ur, uq};
      default:  ;
    endcase
  end

  // State register and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load latency on accept, count down, leave on flush or last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      S_BUSY: begin
        if (flush_w || (cnt_q == CNT_W'(1))) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath next values: shadow capture, MT* writes in idle, commit on last cycle
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_s_d = hi_s_q;
    lo_s_d = lo_s_q;
    if (accept) begin
      hi_s_d = res_hi;
      lo_s_d = res_lo;
    end
    if ((state_q == S_IDLE) && start && !flush_w) begin
      if (md_op == OP_MTHI) hi_d = rs;
      if (md_op == OP_MTLO) lo_d = rs;
    end
    if (commit) begin
      hi_d = hi_s_q;
      lo_d = lo_s_q;
    end
  end

  // HI/LO and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hi_s_q <= '0;
      lo_s_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_s_q <= hi_s_d;
      lo_s_q <= lo_s_d;
    end
  end

  // Busy comes straight from the state flop; stall also covers the issuing cycle
  assign busy     = (state_q == S_BUSY);
  assign md_stall = busy || (start && is_md);
  assign rd_data  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed self-checking bench for md_sequencer.
// Build with MD_FLUSH_EN defined to exercise the flush port as well.
module tb_md_sequencer;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
`ifdef MD_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] rs;
  logic [31:0] rt;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        md_stall;

  int n_checks = 0;
  int n_fail   = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
`ifdef MD_FLUSH_EN
    .flush    (flush),
`endif
    .rs       (rs),
    .rt       (rt),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .busy     (busy),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one command for a single cycle; returns 1ns after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
  endtask

  // Count cycles until busy falls, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    rd_sel = 1'b1; #1; hi = rd_data;
    rd_sel = 1'b0; #1; lo = rd_data;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    rst_n = 1'b0; start = 1'b0; md_op = OP_NONE; rs = '0; rt = '0; rd_sel = 1'b0;
`ifdef MD_FLUSH_EN
    flush = 1'b0;
`endif
    #12;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi();
    logic [31:0] hi, lo;
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; rs = 32'h1234_5678;
    #1;
    n_checks++;
    if (md_stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b want 0", md_stall); end
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'd0) begin
      n_fail++; $display("FAIL mthi_value: got hi=%h lo=%h want 12345678/00000000", hi, lo);
    end
    issue(OP_MTLO, 32'hCAFE_0001, 32'd0);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL mtlo_value: got hi=%h lo=%h want 12345678/cafe0001", hi, lo);
    end
    // NONE and reserved op leave everything alone
    issue(OP_RSVD, 32'h5555_5555, 32'd3);
    issue(OP_NONE, 32'h6666_6666, 32'd3);
    read_hilo(hi, lo);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL nop_ops: got busy=%b hi=%h lo=%h want 0/12345678/cafe0001", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int n;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise: got %b want 1", busy); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL mult_old_during_busy: got hi=%h lo=%h want 12345678/cafe0001", hi, lo);
    end
    wait_idle(n);
    n_checks++;
    if (n != 5) begin n_fail++; $display("FAIL mult_latency: got %0d want 5", n); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_result: got hi=%h lo=%h want ffffffff/fffffffa", hi, lo);
    end
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    read_hilo(hi, lo);
    n_checks++;
    if (n != 5 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL multu_result: got n=%0d hi=%h lo=%h want 5/00000002/fffffffa", n, hi, lo);
    end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL div_latency: got %0d want 10", n); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_result: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
    end
    issue(OP_DIV, 32'd5, 32'd0);
    wait_idle(n);
    read_hilo(hi, lo);
    n_checks++;
    if (n != 10 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL div_by_zero: got n=%0d hi=%h lo=%h want 10/00000005/ffffffff", n, hi, lo);
    end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int n;
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    // Issue in the very first idle cycle after busy falls
    issue(OP_DIVU, 32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      n_fail++; $display("FAIL b2b_first_result: got hi=%h lo=%h want 00000001/00000000", hi, lo);
    end
    wait_idle(n);
    read_hilo(hi, lo);
    n_checks++;
    if (n != 10 || hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++; $display("FAIL b2b_divu: got n=%0d hi=%h lo=%h want 10/00000002/0000000e", n, hi, lo);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] hi, lo;
    logic        stall_ok;
    int n;
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    n = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && n < 50) begin
      if (n == 1) begin
        start = 1'b1; md_op = OP_DIVU; rs = 32'd100; rt = 32'd7;
      end else if (n == 2) begin
        start = 1'b1; md_op = OP_MTLO; rs = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; md_op = OP_NONE;
      end
      #1;
      if (md_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; md_op = OP_NONE;
    n_checks++;
    if (n != 5) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want 5", n); end
    n_checks++;
    if (stall_ok !== 1'b1) begin n_fail++; $display("FAIL busy_stall: got dropped want held 1"); end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL busy_ignore_result: got hi=%h lo=%h want 00000002/fffffffa", hi, lo);
    end
    idle_cycles(12);
    read_hilo(hi, lo);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL busy_ignore_late: got busy=%b hi=%h lo=%h want 0/00000002/fffffffa", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] hi, lo;
    issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
    issue(OP_MULT, 32'd7, 32'd9);
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_busy: got busy=%b stall=%b want 0/0", busy, md_stall);
    end
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(12);
    read_hilo(hi, lo);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_no_commit: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

`ifdef MD_FLUSH_EN
  task automatic test_flush();
    logic [31:0] hi, lo;
    issue(OP_MTHI, 32'h0BAD_F00D, 32'd0);
    issue(OP_MTLO, 32'h0000_1111, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    idle_cycles(2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    idle_cycles(12);
    read_hilo(hi, lo);
    n_checks++;
    if (hi !== 32'h0BAD_F00D || lo !== 32'h0000_1111) begin
      n_fail++; $display("FAIL flush_hilo: got hi=%h lo=%h want 0badf00d/00001111", hi, lo);
    end
    // Flush in idle suppresses a same-cycle start
    @(negedge clk);
    flush = 1'b1; start = 1'b1; md_op = OP_MULT; rs = 32'd3; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b1; md_op = OP_MTLO; rs = 32'h7777_7777;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; md_op = OP_NONE;
    read_hilo(hi, lo);
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0BAD_F00D || lo !== 32'h0000_1111) begin
      n_fail++; $display("FAIL flush_idle: got busy=%b hi=%h lo=%h want 0/0badf00d/00001111", busy, hi, lo);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mthi();
    test_mult();
    test_div();
    test_back_to_back();
    test_start_while_busy();
`ifdef MD_FLUSH_EN
    test_flush();
`endif
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
